// File: rtl/lcd_master_stream_arbiter_if.sv
// ----------------------------------------------------------------------------
// lcd_master_stream_arbiter_if
//
// Purpose:
//   Bundles the two Avalon-ST input channels (command = ch0, pixel = ch1)
//   and the merged 8-bit output stream of the LCD master packet arbiter.
//
// Modports:
//   master : arbiter view. Consumes inX_valid/data/sop/eop and out_ready,
//            drives inX_ready and the registered out_* beat.
//   slave  : environment view (sources + LCD master timing adapter),
//            the exact mirror of master.
// ----------------------------------------------------------------------------
interface lcd_master_stream_arbiter_if;
    // channel 0 (command)
    logic       in0_valid;
    logic [7:0] in0_data;
    logic       in0_sop;
    logic       in0_eop;
    logic       in0_ready;
    // channel 1 (pixel data)
    logic       in1_valid;
    logic [7:0] in1_data;
    logic       in1_sop;
    logic       in1_eop;
    logic       in1_ready;
    // merged output stream
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       out_channel;
    logic       out_ready;

    modport master (
        input  in0_valid, in0_data, in0_sop, in0_eop,
        output in0_ready,
        input  in1_valid, in1_data, in1_sop, in1_eop,
        output in1_ready,
        output out_valid, out_data, out_sop, out_eop, out_channel,
        input  out_ready
    );

    modport slave (
        output in0_valid, in0_data, in0_sop, in0_eop,
        input  in0_ready,
        output in1_valid, in1_data, in1_sop, in1_eop,
        input  in1_ready,
        input  out_valid, out_data, out_sop, out_eop, out_channel,
        output out_ready
    );
endinterface

// File: rtl/lcd_master_stream_arbiter.sv
// ----------------------------------------------------------------------------
// lcd_master_stream_arbiter
//
// Purpose:
//   Two-requester Avalon-ST packet arbiter in front of the 8-bit LCD master
//   byte stream. One input owns the output for a whole packet (sop..eop);
//   ownership alternates round-robin between packets. The output beat is
//   registered. Packets longer than MAX_BEATS are cut: beat MAX_BEATS leaves
//   with out_eop forced, the remainder of the source packet is swallowed.
//
// Parameters:
//   MAX_BEATS : maximum beats per packet including sop and eop
//   CNT_W     : beat counter width, 2**CNT_W must exceed MAX_BEATS
//
// Ports:
//   clk        : single clock, everything on the rising edge
//   reset      : synchronous, active-high reset
//   bus        : lcd_master_stream_arbiter_if.master
//                  in0_* / in1_* : input channels (valid/data/sop/eop/ready)
//                  out_*         : registered output beat + out_channel,
//                                  out_ready from the downstream adapter
//   orphan_err : 1-cycle pulse, a beat without sop was discarded in IDLE
//   trunc_err  : 1-cycle pulse, a packet was truncated at MAX_BEATS
//                (coincides with the forced-eop output beat)
//
// Configuration macro:
//   LCD_ARB_FIXED_PRIO_EN : when defined, IDLE ties always go to channel 0
//                           and the last-grant history is ignored. Ports and
//                           latency are the same in both builds.
// ----------------------------------------------------------------------------
module lcd_master_stream_arbiter #(
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 9
) (
    input  logic                               clk,
    input  logic                               reset,
    lcd_master_stream_arbiter_if.master        bus,
    output logic                               orphan_err,
    output logic                               trunc_err
);

    // Counter value after the last permitted beat, and the value that marks
    // "the next accepted beat is the last permitted one".
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    // GRANTx moves a packet; DRAINx is the truncation sub-state of GRANTx
    // that swallows the rest of an over-long packet up to its eop.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT0 = 3'd1,
        GRANT1 = 3'd2,
        DRAIN0 = 3'd3,
        DRAIN1 = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic             last_grant_reg, last_grant_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic             out_valid_reg;
    logic [7:0]       out_data_reg;
    logic             out_sop_reg;
    logic             out_eop_reg;
    logic             out_channel_reg;
    logic             orphan_err_reg;
    logic             trunc_err_reg;

    // Inputs gathered into channel-indexed form.
    logic [1:0]       in_valid;
    logic [1:0]       in_sop;
    logic [1:0]       in_eop;
    logic [7:0]       in_data [2];
    logic [1:0]       cand;

    // Combinational decisions.
    logic [1:0]       ready;
    logic             load;
    logic             sel;
    logic             force_eop;
    logic             trunc_set;
    logic             orphan_set;
    logic             out_free;
    logic             idle_pick;
    logic             cur_ch;

    assign in_valid   = {bus.in1_valid, bus.in0_valid};
    assign in_sop     = {bus.in1_sop,   bus.in0_sop};
    assign in_eop     = {bus.in1_eop,   bus.in0_eop};
    assign in_data[0] = bus.in0_data;
    assign in_data[1] = bus.in1_data;

    // A channel competes for the output only with a valid sop beat.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cand
            assign cand[gi] = in_valid[gi] & in_sop[gi];
        end
    endgenerate

    // The output register can take a new beat when empty or being drained.
    assign out_free = !out_valid_reg || bus.out_ready;

    // Channel owning the current packet in GRANTx / DRAINx.
    assign cur_ch = (state_reg == GRANT1) || (state_reg == DRAIN1);

    // Tie-break in IDLE. With a single candidate the pick is that channel
    // (cand[1] alone selects 1, cand[0] alone selects 0).
`ifdef LCD_ARB_FIXED_PRIO_EN
    assign idle_pick = (cand == 2'b11) ? 1'b0 : cand[1];
`else
    assign idle_pick = (cand == 2'b11) ? ~last_grant_reg : cand[1];
`endif

    // ------------------------------------------------------------------
    // Next-state / handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        ready           = 2'b00;
        load            = 1'b0;
        sel             = 1'b0;
        force_eop       = 1'b0;
        trunc_set       = 1'b0;
        orphan_set      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // Beats without sop cannot start a packet: swallow them so
                // a confused source does not block the arbiter forever.
                for (int i = 0; i < 2; i++) begin
                    if (in_valid[i] && !in_sop[i]) begin
                        ready[i]   = 1'b1;
                        orphan_set = 1'b1;
                    end
                end
                // The grant takes effect immediately: the sop beat itself
                // is accepted in IDLE, so back-to-back packets lose at most
                // one cycle.
                if (|cand) begin
                    sel = idle_pick;
                    if (out_free) begin
                        ready[idle_pick] = 1'b1;
                        load             = 1'b1;
                        if (in_eop[idle_pick]) begin
                            // single-beat packet: stay in IDLE
                            last_grant_next = idle_pick;
                            beat_cnt_next   = '0;
                        end else if (MAX_BEATS == 1) begin
                            force_eop     = 1'b1;
                            trunc_set     = 1'b1;
                            beat_cnt_next = MAX_CNT;
                            state_next    = idle_pick ? DRAIN1 : DRAIN0;
                        end else begin
                            beat_cnt_next = CNT_W'(1);
                            state_next    = idle_pick ? GRANT1 : GRANT0;
                        end
                    end
                end
            end

            GRANT0, GRANT1: begin
                sel           = cur_ch;
                ready[cur_ch] = out_free;
                if (in_valid[cur_ch] && out_free) begin
                    load = 1'b1;
                    if (in_eop[cur_ch]) begin
                        state_next      = IDLE;
                        last_grant_next = cur_ch;
                        beat_cnt_next   = '0;
                    end else if (beat_cnt_reg == LAST_CNT) begin
                        // This is beat MAX_BEATS and the source is still
                        // going: close the output packet here. The counter
                        // parks at MAX_BEATS rather than wrapping.
                        force_eop     = 1'b1;
                        trunc_set     = 1'b1;
                        beat_cnt_next = MAX_CNT;
                        state_next    = cur_ch ? DRAIN1 : DRAIN0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end

            DRAIN0, DRAIN1: begin
                // Discarded beats never touch the output register, so they
                // are taken regardless of out_ready.
                ready[cur_ch] = 1'b1;
                if (in_valid[cur_ch] && in_eop[cur_ch]) begin
                    state_next      = IDLE;
                    last_grant_next = cur_ch;
                    beat_cnt_next   = '0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // last_grant=1 makes channel 0 win the first tie.
            state_reg       <= IDLE;
            last_grant_reg  <= 1'b1;
            beat_cnt_reg    <= '0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= 8'h00;
            out_sop_reg     <= 1'b0;
            out_eop_reg     <= 1'b0;
            out_channel_reg <= 1'b0;
            orphan_err_reg  <= 1'b0;
            trunc_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
            orphan_err_reg <= orphan_set;
            trunc_err_reg  <= trunc_set;
            // While stalled (out_valid && !out_ready) the whole beat holds.
            if (out_free) begin
                out_valid_reg <= load;
                if (load) begin
                    out_data_reg    <= in_data[sel];
                    out_sop_reg     <= in_sop[sel];
                    out_eop_reg     <= in_eop[sel] | force_eop;
                    out_channel_reg <= sel;
                end
            end
        end
    end

    // Readies are combinational; hold them low during reset so nothing is
    // consumed from the sources while the arbiter is being cleared.
    assign bus.in0_ready   = ready[0] & ~reset;
    assign bus.in1_ready   = ready[1] & ~reset;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_data    = out_data_reg;
    assign bus.out_sop     = out_sop_reg;
    assign bus.out_eop     = out_eop_reg;
    assign bus.out_channel = out_channel_reg;
    assign orphan_err      = orphan_err_reg;
    assign trunc_err       = trunc_err_reg;

endmodule

// File: tb/tb_lcd_master_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lcd_master_stream_arbiter
//
// Directed scenarios (single packet, ties and round-robin, output stall,
// truncation, orphan beats, reset mid-packet) followed by a randomized run.
// The random run checks every output beat against per-channel queues of
// expected packets built from the source packets (truncated to MAX_BEATS
// with a forced eop, orphan beats dropped), checks that packets never
// interleave, that stalled beats hold, and counts truncation pulses.
// DUT is built with MAX_BEATS=4.
// ----------------------------------------------------------------------------
module tb_lcd_master_stream_arbiter;

    localparam int MAXB = 4;

`ifdef LCD_ARB_FIXED_PRIO_EN
    localparam logic RR_FIRST = 1'b0;
`else
    localparam logic RR_FIRST = 1'b1;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    logic orphan_err;
    logic trunc_err;

    int total = 0;
    int bad   = 0;

    lcd_master_stream_arbiter_if bus_if ();

    lcd_master_stream_arbiter #(
        .MAX_BEATS (MAXB),
        .CNT_W     (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .orphan_err (orphan_err),
        .trunc_err  (trunc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Valid output beat: {valid, sop, eop, channel, data}.
    task automatic chk_out(input string tag, input logic [7:0] d, input logic s, input logic e, input logic c);
        chk(tag, {20'd0, bus_if.out_valid, bus_if.out_sop, bus_if.out_eop, bus_if.out_channel, bus_if.out_data},
                 {20'd0, 1'b1, s, e, c, d});
    endtask

    task automatic set_in(input int ch, input logic v, input logic [7:0] d, input logic s, input logic e);
        if (ch == 0) begin
            bus_if.in0_valid = v; bus_if.in0_data = d; bus_if.in0_sop = s; bus_if.in0_eop = e;
        end else begin
            bus_if.in1_valid = v; bus_if.in1_data = d; bus_if.in1_sop = s; bus_if.in1_eop = e;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    beat_t src0_q[$], src1_q[$], exp0_q[$], exp1_q[$];

    initial begin
        beat_t bt, xb, hb;
        logic  acc0, acc1, in_pkt, pkt_ch, hold_pend;
        logic [12:0] held;
        int    len, exp_trunc, trunc_seen, cyc;

        reset = 1'b1;
        set_in(0, 0, 8'h00, 0, 0);
        set_in(1, 0, 8'h00, 0, 0);
        bus_if.out_ready = 1'b1;
        tick();
        tick();
        // ---- reset state ----
        chk("rst_out", {bus_if.out_valid, bus_if.out_sop, bus_if.out_eop, bus_if.out_channel, bus_if.out_data}, 0);
        chk("rst_err", {orphan_err, trunc_err}, 0);
        chk("rst_rdy", {bus_if.in0_ready, bus_if.in1_ready}, 0);
        reset = 1'b0;
        tick();
        chk("idle_out_valid", bus_if.out_valid, 0);

        // ---- 1: single ch0 packet A1,A2,A3 ----
        set_in(0, 1, 8'hA1, 1, 0); #1;
        chk("t1_rdy0", bus_if.in0_ready, 1);
        chk("t1_rdy1", bus_if.in1_ready, 0);
        tick(); chk_out("t1_a1", 8'hA1, 1, 0, 0);
        set_in(0, 1, 8'hA2, 0, 0); #1;
        chk("t1_rdy1b", bus_if.in1_ready, 0);
        tick(); chk_out("t1_a2", 8'hA2, 0, 0, 0);
        set_in(0, 1, 8'hA3, 0, 1); #1;
        chk("t1_rdy1c", bus_if.in1_ready, 0);
        tick(); chk_out("t1_a3", 8'hA3, 0, 1, 0);
        set_in(0, 0, 8'h00, 0, 0);
        tick(); chk("t1_done", bus_if.out_valid, 0);

        // ---- 2: tie after reset, then round-robin ----
        do_reset();
        set_in(0, 1, 8'hB0, 1, 0);
        set_in(1, 1, 8'hC0, 1, 0); #1;
        chk("t2_tie_rdy", {bus_if.in1_ready, bus_if.in0_ready}, 2'b01);
        tick(); chk_out("t2_b0", 8'hB0, 1, 0, 0);
        set_in(0, 1, 8'hB1, 0, 1); #1;
        chk("t2_noint", bus_if.in1_ready, 0);
        tick(); chk_out("t2_b1", 8'hB1, 0, 1, 0);
        set_in(0, 0, 8'h00, 0, 0); #1;
        chk("t2_ch1_rdy", bus_if.in1_ready, 1);
        tick(); chk_out("t2_c0", 8'hC0, 1, 0, 1);
        set_in(1, 1, 8'hC1, 0, 1);
        tick(); chk_out("t2_c1", 8'hC1, 0, 1, 1);
        set_in(1, 0, 8'h00, 0, 0);
        // lone ch0 packet, so ch0 is now the last grant
        set_in(0, 1, 8'hD0, 1, 1);
        tick(); chk_out("t2_d0", 8'hD0, 1, 1, 0);
        set_in(0, 1, 8'hE0, 1, 1);
        set_in(1, 1, 8'hF0, 1, 1); #1;
        chk("t2_rr_rdy", {bus_if.in1_ready, bus_if.in0_ready}, {RR_FIRST, ~RR_FIRST});
        tick();
        if (RR_FIRST) begin
            chk_out("t2_rr_first", 8'hF0, 1, 1, 1);
            set_in(1, 0, 8'h00, 0, 0);
            tick(); chk_out("t2_rr_second", 8'hE0, 1, 1, 0);
            set_in(0, 0, 8'h00, 0, 0);
        end else begin
            chk_out("t2_rr_first", 8'hE0, 1, 1, 0);
            set_in(0, 0, 8'h00, 0, 0);
            tick(); chk_out("t2_rr_second", 8'hF0, 1, 1, 1);
            set_in(1, 0, 8'h00, 0, 0);
        end
        tick(); chk("t2_done", bus_if.out_valid, 0);

        // ---- 3: out_ready low mid-packet; 4-beat packet ending exactly at the limit ----
        set_in(0, 1, 8'h50, 1, 0);
        tick(); chk_out("t3_f0", 8'h50, 1, 0, 0);
        set_in(0, 1, 8'h51, 0, 0);
        tick(); chk_out("t3_f1", 8'h51, 0, 0, 0);
        set_in(0, 1, 8'h52, 0, 0);
        bus_if.out_ready = 1'b0; #1;
        chk("t3_stall_rdy", bus_if.in0_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("t3_hold", 8'h51, 0, 0, 0);
            chk("t3_hold_rdy", bus_if.in0_ready, 0);
        end
        bus_if.out_ready = 1'b1; #1;
        chk("t3_resume_rdy", bus_if.in0_ready, 1);
        tick(); chk_out("t3_f2", 8'h52, 0, 0, 0);
        set_in(0, 1, 8'h53, 0, 1);
        tick(); chk_out("t3_f3", 8'h53, 0, 1, 0);
        chk("t3_no_trunc", trunc_err, 0);
        set_in(0, 0, 8'h00, 0, 0);
        tick(); chk("t3_done", bus_if.out_valid, 0);

        // ---- 4: ch1 6-beat packet truncated at 4, ch0 waiting ----
        set_in(1, 1, 8'h60, 1, 0);
        tick(); chk_out("t4_g0", 8'h60, 1, 0, 1);
        set_in(1, 1, 8'h61, 0, 0);
        set_in(0, 1, 8'h70, 1, 1); #1;
        chk("t4_rdy0_blocked", bus_if.in0_ready, 0);
        tick(); chk_out("t4_g1", 8'h61, 0, 0, 1);
        set_in(1, 1, 8'h62, 0, 0);
        tick(); chk_out("t4_g2", 8'h62, 0, 0, 1);
        chk("t4_no_trunc_yet", trunc_err, 0);
        set_in(1, 1, 8'h63, 0, 0);
        tick(); chk_out("t4_g3_forced_eop", 8'h63, 0, 1, 1);
        chk("t4_trunc_pulse", trunc_err, 1);
        set_in(1, 1, 8'h64, 0, 0); #1;
        chk("t4_drain_rdy", {bus_if.in1_ready, bus_if.in0_ready}, 2'b10);
        tick(); chk("t4_drop5", bus_if.out_valid, 0);
        chk("t4_trunc_end", trunc_err, 0);
        set_in(1, 1, 8'h65, 0, 1);
        tick(); chk("t4_drop6", bus_if.out_valid, 0);
        set_in(1, 0, 8'h00, 0, 0); #1;
        chk("t4_ch0_rdy", bus_if.in0_ready, 1);
        tick(); chk_out("t4_h0", 8'h70, 1, 1, 0);
        set_in(0, 0, 8'h00, 0, 0);
        tick(); chk("t4_done", bus_if.out_valid, 0);

        // ---- 5: orphan beat in IDLE ----
        set_in(0, 1, 8'h99, 0, 0); #1;
        chk("t5_orphan_rdy", bus_if.in0_ready, 1);
        tick();
        chk("t5_orphan_pulse", orphan_err, 1);
        chk("t5_no_out", bus_if.out_valid, 0);
        set_in(0, 0, 8'h00, 0, 0);
        tick();
        chk("t5_pulse_end", orphan_err, 0);

        // ---- 6: reset during beat 2 ----
        set_in(1, 1, 8'h80, 1, 0);
        tick(); chk_out("t6_j0", 8'h80, 1, 0, 1);
        set_in(1, 1, 8'h81, 0, 0);
        reset = 1'b1;
        tick();
        chk("t6_rst_out", {bus_if.out_valid, bus_if.out_sop, bus_if.out_eop, bus_if.out_channel, bus_if.out_data}, 0);
        chk("t6_rst_rdy", {bus_if.in0_ready, bus_if.in1_ready}, 0);
        reset = 1'b0;
        set_in(1, 0, 8'h00, 0, 0);
        tick(); chk("t6_idle", bus_if.out_valid, 0);
        set_in(0, 1, 8'h90, 1, 0);
        set_in(1, 1, 8'hA0, 1, 1);
        tick(); chk_out("t6_ch0_wins", 8'h90, 1, 0, 0);
        set_in(0, 1, 8'h91, 0, 1);
        tick(); chk_out("t6_k1", 8'h91, 0, 1, 0);
        set_in(0, 0, 8'h00, 0, 0);
        tick(); chk_out("t6_l0", 8'hA0, 1, 1, 1);
        set_in(1, 0, 8'h00, 0, 0);
        tick();

        // ---- randomized run ----
        exp_trunc = 0;
        for (int ch = 0; ch < 2; ch++) begin
            for (int p = 0; p < 25; p++) begin
                if ($urandom_range(0, 5) == 0) begin
                    bt.d = 8'($urandom); bt.s = 1'b0; bt.e = 1'b0;
                    if (ch == 0) src0_q.push_back(bt); else src1_q.push_back(bt);
                end
                len = $urandom_range(1, 6);
                if (len > MAXB) exp_trunc++;
                for (int b = 0; b < len; b++) begin
                    bt.d = 8'($urandom);
                    bt.s = (b == 0);
                    bt.e = (b == len - 1);
                    if (ch == 0) src0_q.push_back(bt); else src1_q.push_back(bt);
                    if (b < MAXB) begin
                        xb = bt;
                        if (b == MAXB - 1) xb.e = 1'b1;
                        if (ch == 0) exp0_q.push_back(xb); else exp1_q.push_back(xb);
                    end
                end
            end
        end

        trunc_seen = 0;
        in_pkt     = 1'b0;
        pkt_ch     = 1'b0;
        hold_pend  = 1'b0;
        held       = '0;
        cyc        = 0;
        while (cyc < 6000 && (src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size()) != 0) begin
            @(negedge clk);
            acc0 = bus_if.in0_valid && bus_if.in0_ready;
            acc1 = bus_if.in1_valid && bus_if.in1_ready;
            if (hold_pend)
                chk("rnd_hold", {19'd0, bus_if.out_valid, bus_if.out_channel, bus_if.out_sop, bus_if.out_eop, bus_if.out_data},
                                {19'd0, held});
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (in_pkt) chk("rnd_interleave", bus_if.out_channel, pkt_ch);
                pkt_ch = bus_if.out_channel;
                if (bus_if.out_channel == 1'b0) begin
                    chk("rnd_exp0_avail", exp0_q.size() != 0, 1);
                    if (exp0_q.size() != 0) begin
                        hb = exp0_q.pop_front();
                        chk("rnd_beat0", {bus_if.out_data, bus_if.out_sop, bus_if.out_eop}, hb);
                    end
                end else begin
                    chk("rnd_exp1_avail", exp1_q.size() != 0, 1);
                    if (exp1_q.size() != 0) begin
                        hb = exp1_q.pop_front();
                        chk("rnd_beat1", {bus_if.out_data, bus_if.out_sop, bus_if.out_eop}, hb);
                    end
                end
                in_pkt = !bus_if.out_eop;
            end
            hold_pend = bus_if.out_valid && !bus_if.out_ready;
            held = {1'b1, bus_if.out_channel, bus_if.out_sop, bus_if.out_eop, bus_if.out_data};
            if (trunc_err) trunc_seen++;
            tick();
            if (acc0) void'(src0_q.pop_front());
            if (acc1) void'(src1_q.pop_front());
            // a presented beat stays valid until it is taken
            if (acc0 || !bus_if.in0_valid) begin
                if (src0_q.size() != 0 && $urandom_range(0, 3) != 0)
                    set_in(0, 1, src0_q[0].d, src0_q[0].s, src0_q[0].e);
                else
                    set_in(0, 0, 8'h00, 0, 0);
            end
            if (acc1 || !bus_if.in1_valid) begin
                if (src1_q.size() != 0 && $urandom_range(0, 3) != 0)
                    set_in(1, 1, src1_q[0].d, src1_q[0].s, src1_q[0].e);
                else
                    set_in(1, 0, 8'h00, 0, 0);
            end
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("rnd_finished_in_time", cyc < 6000, 1);
        chk("rnd_left_over", src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size(), 0);
        chk("rnd_trunc_count", trunc_seen, exp_trunc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
